// File: rtl/number_spawn_controller_pkg.sv
// Shared types, constants and digit helpers for the number spawn controller.
// Optional feature macro: NUMBER_RANDOM_VALUES_EN (LFSR-driven respawn digits).
package number_ctrl_pkg;

    typedef enum logic [1:0] {
        SHOWN  = 2'd0,
        HIDDEN = 2'd1,
        RELOAD = 2'd2
    } slot_state_e;

    localparam logic [3:0] MAX_DIGIT = 4'd9;
    localparam int         TIMER_W   = 9;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [3:0] init_digit(input int slot);
        return 4'((slot % 9) + 1);
    endfunction

    function automatic logic [3:0] next_digit(input logic [3:0] prev,
                                              input logic [3:0] rnd,
                                              input logic       use_rnd);
        logic [3:0] r;
        r = rnd % MAX_DIGIT;
        if (use_rnd) return r + 4'd1;
        return (prev >= MAX_DIGIT) ? 4'd1 : prev + 4'd1;
    endfunction

endpackage

// File: rtl/number_spawn_controller_if.sv
// Bus between collision/frame logic (master) and the number spawn controller (slave).
// Optional feature macro: NUMBER_RANDOM_VALUES_EN (does not change this interface).
interface number_spawn_controller_if #(
    parameter int NUMBERS = 3,
    parameter int SCORE_W = 16
);
    logic                    startOfFrame;
    logic                    gameRestart;
    logic [NUMBERS-1:0]      singleHit;
    logic [NUMBERS-1:0][3:0] numbersToShow;
    logic [NUMBERS-1:0]      showNum;
    logic [SCORE_W-1:0]      score;
    logic                    scoreAdd;
    logic                    pendingAny;

    modport master (
        output startOfFrame, gameRestart, singleHit,
        input  numbersToShow, showNum, score, scoreAdd, pendingAny
    );

    modport slave (
        input  startOfFrame, gameRestart, singleHit,
        output numbersToShow, showNum, score, scoreAdd, pendingAny
    );
endinterface

// File: rtl/number_spawn_controller_slot_fsm.sv
// One number slot: SHOWN/HIDDEN/RELOAD state, hide timer, current digit and latched hit value.
// Optional feature macro: NUMBER_RANDOM_VALUES_EN (new digit is supplied by the top).
module number_slot_fsm
    import number_ctrl_pkg::*;
#(
    parameter int         HIDE_FRAMES = 450,
    parameter logic [3:0] INIT_DIGIT  = 4'd1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       restart,
    input  logic       start_of_frame,
    input  logic       hit,
    input  logic [3:0] new_digit,
    output logic [3:0] digit,
    output logic [3:0] hit_value,
    output logic       shown,
    output logic       hit_accept
);
    slot_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         digit_q, digit_d;
    logic [3:0]         hit_value_q, hit_value_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        timer_d     = timer_q;
        digit_d     = digit_q;
        hit_value_d = hit_value_q;
        hit_accept  = 1'b0;
        if (restart) begin
            state_d = SHOWN;
            timer_d = '0;
            digit_d = INIT_DIGIT;
        end else begin
            case (state_q)
                SHOWN: begin
                    // A frame pulse coinciding with the hit is not counted.
                    if (hit) begin
                        state_d     = HIDDEN;
                        timer_d     = TIMER_W'(HIDE_FRAMES);
                        hit_value_d = digit_q;
                        hit_accept  = 1'b1;
                    end
                end
                HIDDEN: begin
                    if (start_of_frame) begin
                        timer_d = timer_q - TIMER_W'(1);
                        if (timer_q == TIMER_W'(1)) state_d = RELOAD;
                    end
                end
                RELOAD: begin
                    digit_d = new_digit;
                    state_d = SHOWN;
                end
                default: state_d = SHOWN;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= SHOWN;
            timer_q     <= '0;
            digit_q     <= INIT_DIGIT;
            hit_value_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            digit_q     <= digit_d;
            hit_value_q <= hit_value_d;
        end
    end

    assign digit     = digit_q;
    assign hit_value = hit_value_q;
    assign shown     = (state_q == SHOWN);
endmodule

// File: rtl/number_spawn_controller.sv
// Number slot sequencer: per-slot FSMs, fixed-priority hit scoring and a saturating score.
// Optional feature macro: NUMBER_RANDOM_VALUES_EN (respawn digits taken from an 8-bit LFSR).
module number_spawn_controller
    import number_ctrl_pkg::*;
#(
    parameter int NUMBERS     = 3,
    parameter int HIDE_FRAMES = 450,
    parameter int SCORE_W     = 16
) (
    input logic                        clk,
    input logic                        resetN,
    number_spawn_controller_if.slave   bus
);
    logic [NUMBERS-1:0]      hit_accept;
    logic [NUMBERS-1:0][3:0] hit_value;
    logic [NUMBERS-1:0][3:0] digit;
    logic [NUMBERS-1:0]      shown;
    logic [NUMBERS-1:0]      pending_q, pending_d;
    logic [NUMBERS-1:0]      grant;
    logic [3:0]              sel_value;
    logic [SCORE_W:0]        sum;
    logic [SCORE_W-1:0]      score_q, score_d;
    logic                    score_add_q, score_add_d;
    logic [3:0]              rnd;

`ifdef NUMBER_RANDOM_VALUES_EN
    localparam logic RANDOM_EN = 1'b1;
    logic [7:0] lfsr_q, lfsr_d;

    // Free-running: gameRestart deliberately leaves the sequence alone.
    assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign rnd = lfsr_q[3:0];
`else
    localparam logic RANDOM_EN = 1'b0;
    assign rnd = 4'h0;
`endif

    for (genvar i = 0; i < NUMBERS; i++) begin : g_slot
        number_slot_fsm #(
            .HIDE_FRAMES (HIDE_FRAMES),
            .INIT_DIGIT  (init_digit(i))
        ) u_slot (
            .clk            (clk),
            .resetN         (resetN),
            .restart        (bus.gameRestart),
            .start_of_frame (bus.startOfFrame),
            .hit            (bus.singleHit[i]),
            .new_digit      (next_digit(digit[i], rnd, RANDOM_EN)),
            .digit          (digit[i]),
            .hit_value      (hit_value[i]),
            .shown          (shown[i]),
            .hit_accept     (hit_accept[i])
        );
    end

    always_comb begin
        // Isolate the lowest set pending bit: that slot is scored this cycle.
        grant     = pending_q & (~pending_q + NUMBERS'(1));
        sel_value = '0;
        for (int i = 0; i < NUMBERS; i++) begin
            if (grant[i]) sel_value = hit_value[i];
        end
        sum         = {1'b0, score_q} + (SCORE_W+1)'(sel_value);
        pending_d   = (pending_q & ~grant) | hit_accept;
        score_d     = score_q;
        score_add_d = 1'b0;
        if (|pending_q) begin
            score_d     = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
            score_add_d = 1'b1;
        end
        if (bus.gameRestart) begin
            pending_d   = '0;
            score_d     = '0;
            score_add_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pending_q   <= '0;
            score_q     <= '0;
            score_add_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            score_q     <= score_d;
            score_add_q <= score_add_d;
        end
    end

    // A slot stays hidden for at least a frame, so it can never be re-hit while still pending.
    assert property (@(posedge clk) disable iff (!resetN) (hit_accept & pending_q) == '0);

    assign bus.numbersToShow = digit;
    assign bus.showNum       = shown;
    assign bus.score         = score_q;
    assign bus.scoreAdd      = score_add_q;
    assign bus.pendingAny    = |pending_q;
endmodule

// File: tb/tb_number_spawn_controller.sv
// Self-checking bench for number_spawn_controller: a 3-slot game instance and a 9-slot 4-bit-score instance.
// Honours NUMBER_RANDOM_VALUES_EN for the respawned digit check.
module tb_number_spawn_controller;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   model_m = 0;
    int   model_s = 0;
    int   exp_m[$];
    int   exp_s[$];

    always #5 clk = ~clk;

    number_spawn_controller_if #(.NUMBERS(3), .SCORE_W(16)) m_if ();
    number_spawn_controller_if #(.NUMBERS(9), .SCORE_W(4))  s_if ();

    number_spawn_controller #(.NUMBERS(3), .HIDE_FRAMES(450), .SCORE_W(16)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (m_if)
    );

    number_spawn_controller #(.NUMBERS(9), .HIDE_FRAMES(4), .SCORE_W(4)) dut_sat (
        .clk    (clk),
        .resetN (resetN),
        .bus    (s_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_m(input int d);
        model_m = model_m + d;
        exp_m.push_back(model_m);
    endtask

    task automatic push_s(input int d);
        model_s = (model_s + d > 15) ? 15 : model_s + d;
        exp_s.push_back(model_s);
    endtask

    // Scoreboard: every scoreAdd pulse must match the next expected score.
    always @(negedge clk) begin
        if (resetN) begin
            if (m_if.scoreAdd) begin
                vectors++;
                if (exp_m.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_main: unexpected scoreAdd, score=%0d", m_if.score);
                end else begin
                    int e;
                    e = exp_m.pop_front();
                    if (m_if.score !== 16'(e)) begin
                        miscompares++;
                        $display("FAIL sb_main: score=%0d expected=%0d", m_if.score, e);
                    end
                end
            end
            if (s_if.scoreAdd) begin
                vectors++;
                if (exp_s.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_sat: unexpected scoreAdd, score=%0d", s_if.score);
                end else begin
                    int e;
                    e = exp_s.pop_front();
                    if (s_if.score !== 4'(e)) begin
                        miscompares++;
                        $display("FAIL sb_sat: score=%0d expected=%0d", s_if.score, e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        #12;
        vectors++;
        if (m_if.showNum !== 3'b111 || m_if.numbersToShow !== 12'h321 || m_if.score !== 16'd0 ||
            m_if.scoreAdd !== 1'b0 || m_if.pendingAny !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: show=%b digits=%h score=%0d add=%b pend=%b expected 111/321/0/0/0",
                     m_if.showNum, m_if.numbersToShow, m_if.score, m_if.scoreAdd, m_if.pendingAny);
        end
        vectors++;
        if (s_if.numbersToShow !== 36'h987654321 || s_if.score !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_sat: digits=%h score=%0d expected 987654321/0", s_if.numbersToShow, s_if.score);
        end
        @(negedge clk);
        resetN = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            tick();
            vectors++;
            if (m_if.showNum !== 3'b111 || m_if.numbersToShow !== 12'h321 || m_if.score !== 16'd0) begin
                miscompares++;
                $display("FAIL idle_%0d: show=%b digits=%h score=%0d expected 111/321/0",
                         c, m_if.showNum, m_if.numbersToShow, m_if.score);
            end
        end
    endtask

    task automatic test_simultaneous();
        m_if.singleHit = 3'b111;
        push_m(1); push_m(2); push_m(3);
        tick();
        m_if.singleHit = 3'b000;
        vectors++;
        if (m_if.showNum !== 3'b000 || m_if.scoreAdd !== 1'b0 || m_if.pendingAny !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_hit: show=%b add=%b pend=%b expected 000/0/1", m_if.showNum, m_if.scoreAdd, m_if.pendingAny);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if (m_if.scoreAdd !== 1'b1 || m_if.score !== 16'(k * (k + 1) / 2)) begin
                miscompares++;
                $display("FAIL simul_serve_%0d: add=%b score=%0d expected 1/%0d", k, m_if.scoreAdd, m_if.score, k * (k + 1) / 2);
            end
        end
        tick();
        vectors++;
        if (m_if.scoreAdd !== 1'b0 || m_if.pendingAny !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_done: add=%b pend=%b expected 0/0", m_if.scoreAdd, m_if.pendingAny);
        end
        // Hidden slots ignore hits.
        m_if.singleHit = 3'b111;
        tick();
        m_if.singleHit = 3'b000;
        repeat (5) tick();
        vectors++;
        if (m_if.score !== 16'd6 || m_if.pendingAny !== 1'b0 || exp_m.size() != 0) begin
            miscompares++;
            $display("FAIL hidden_hits: score=%0d pend=%b queued=%0d expected 6/0/0", m_if.score, m_if.pendingAny, exp_m.size());
        end
    endtask

    task automatic test_restart();
        m_if.gameRestart = 1'b1;
        tick();
        m_if.gameRestart = 1'b0;
        model_m = 0;
        vectors++;
        if (m_if.showNum !== 3'b111 || m_if.score !== 16'd0 || m_if.numbersToShow !== 12'h321) begin
            miscompares++;
            $display("FAIL restart_idle: show=%b score=%0d digits=%h expected 111/0/321", m_if.showNum, m_if.score, m_if.numbersToShow);
        end
        m_if.singleHit = 3'b110;
        tick();
        m_if.singleHit = 3'b000;
        vectors++;
        if (m_if.pendingAny !== 1'b1 || m_if.showNum !== 3'b001) begin
            miscompares++;
            $display("FAIL restart_pending: pend=%b show=%b expected 1/001", m_if.pendingAny, m_if.showNum);
        end
        m_if.gameRestart = 1'b1;
        tick();
        m_if.gameRestart = 1'b0;
        vectors++;
        if (m_if.score !== 16'd0 || m_if.scoreAdd !== 1'b0 || m_if.showNum !== 3'b111 ||
            m_if.numbersToShow !== 12'h321 || m_if.pendingAny !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_override: score=%0d add=%b show=%b digits=%h pend=%b expected 0/0/111/321/0",
                     m_if.score, m_if.scoreAdd, m_if.showNum, m_if.numbersToShow, m_if.pendingAny);
        end
        repeat (3) tick();
        vectors++;
        if (m_if.score !== 16'd0) begin
            miscompares++;
            $display("FAIL restart_after: score=%0d expected 0", m_if.score);
        end
    endtask

    task automatic test_single_hit();
        m_if.singleHit = 3'b010;
        push_m(2);
        tick();
        m_if.singleHit = 3'b000;
        vectors++;
        if (m_if.showNum !== 3'b101 || m_if.pendingAny !== 1'b1 || m_if.scoreAdd !== 1'b0) begin
            miscompares++;
            $display("FAIL single_hide: show=%b pend=%b add=%b expected 101/1/0", m_if.showNum, m_if.pendingAny, m_if.scoreAdd);
        end
        tick();
        vectors++;
        if (m_if.score !== 16'd2 || m_if.scoreAdd !== 1'b1) begin
            miscompares++;
            $display("FAIL single_score: score=%0d add=%b expected 2/1", m_if.score, m_if.scoreAdd);
        end
        tick();
        for (int f = 1; f <= 451; f++) begin
            m_if.startOfFrame = 1'b1;
            // Slot 0 is hit on the first frame pulse: that pulse must not count for it.
            if (f == 1) begin
                m_if.singleHit = 3'b001;
                push_m(1);
            end
            tick();
            m_if.startOfFrame = 1'b0;
            m_if.singleHit = 3'b000;
            if (f == 449 || f == 450) begin
                vectors++;
                if (m_if.showNum[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL still_hidden_f%0d: showNum[1]=%b expected 0", f, m_if.showNum[1]);
                end
            end
            if (f == 451) begin
                vectors++;
                if (m_if.showNum[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL slot0_hidden_f451: showNum[0]=%b expected 0", m_if.showNum[0]);
                end
            end
            if (f == 100) m_if.singleHit = 3'b011;
            tick();
            m_if.singleHit = 3'b000;
            if (f == 450) begin
                vectors++;
`ifdef NUMBER_RANDOM_VALUES_EN
                if (m_if.showNum !== 3'b110 || m_if.numbersToShow[1] < 4'd1 || m_if.numbersToShow[1] > 4'd9) begin
`else
                if (m_if.showNum !== 3'b110 || m_if.numbersToShow[1] !== 4'd3) begin
`endif
                    miscompares++;
                    $display("FAIL slot1_reappear: show=%b digit=%0d expected 110/3", m_if.showNum, m_if.numbersToShow[1]);
                end
            end
            if (f == 451) begin
                vectors++;
`ifdef NUMBER_RANDOM_VALUES_EN
                if (m_if.showNum !== 3'b111 || m_if.numbersToShow[0] < 4'd1 || m_if.numbersToShow[0] > 4'd9) begin
`else
                if (m_if.showNum !== 3'b111 || m_if.numbersToShow[0] !== 4'd2) begin
`endif
                    miscompares++;
                    $display("FAIL slot0_reappear: show=%b digit=%0d expected 111/2", m_if.showNum, m_if.numbersToShow[0]);
                end
            end
            repeat (6) tick();
        end
        vectors++;
        if (m_if.score !== 16'd3 || exp_m.size() != 0) begin
            miscompares++;
            $display("FAIL single_total: score=%0d queued=%0d expected 3/0", m_if.score, exp_m.size());
        end
    endtask

    task automatic test_saturation();
        s_if.singleHit = 9'b1_0001_0000;
        push_s(5); push_s(9);
        tick();
        s_if.singleHit = '0;
        repeat (3) tick();
        vectors++;
        if (s_if.score !== 4'd14 || s_if.pendingAny !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_preload: score=%0d pend=%b expected 14/0", s_if.score, s_if.pendingAny);
        end
        s_if.singleHit = 9'b0_0000_0100;
        push_s(3);
        tick();
        s_if.singleHit = '0;
        tick();
        vectors++;
        if (s_if.score !== 4'd15 || s_if.scoreAdd !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_clip: score=%0d add=%b expected 15/1", s_if.score, s_if.scoreAdd);
        end
        tick();
        s_if.singleHit = 9'b0_0000_0001;
        push_s(1);
        tick();
        s_if.singleHit = '0;
        tick();
        vectors++;
        if (s_if.score !== 4'd15 || s_if.scoreAdd !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_hold: score=%0d add=%b expected 15/1", s_if.score, s_if.scoreAdd);
        end
        repeat (2) tick();
        vectors++;
        if (exp_s.size() != 0) begin
            miscompares++;
            $display("FAIL sat_drain: %0d expected scores never produced, required 0", exp_s.size());
        end
    endtask

    task automatic test_async_reset();
        m_if.singleHit = 3'b100;
        push_m(3);
        tick();
        m_if.singleHit = 3'b000;
        repeat (3) tick();
        m_if.startOfFrame = 1'b1;
        tick();
        m_if.startOfFrame = 1'b0;
        vectors++;
        if (m_if.showNum !== 3'b011 || m_if.score !== 16'd6) begin
            miscompares++;
            $display("FAIL pre_reset: show=%b score=%0d expected 011/6", m_if.showNum, m_if.score);
        end
        #2;
        resetN = 1'b0;
        #1;
        vectors++;
        if (m_if.showNum !== 3'b111 || m_if.score !== 16'd0 || m_if.pendingAny !== 1'b0 || s_if.score !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: show=%b score=%0d pend=%b sat_score=%0d expected 111/0/0/0",
                     m_if.showNum, m_if.score, m_if.pendingAny, s_if.score);
        end
        exp_m.delete();
        exp_s.delete();
        @(negedge clk);
        resetN = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        m_if.startOfFrame = 1'b0;
        m_if.gameRestart  = 1'b0;
        m_if.singleHit    = '0;
        s_if.startOfFrame = 1'b0;
        s_if.gameRestart  = 1'b0;
        s_if.singleHit    = '0;
        test_reset();
        test_simultaneous();
        test_restart();
        test_single_hit();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
